// File: rtl/fill_valve_arbiter_pkg.sv
// Shared types and constants for the two-line fill valve arbiter.
// Included by fill_valve_arbiter and fill_timer.
package fill_valve_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OPEN   = 2'd1,
        SETTLE = 2'd2
    } fv_state_t;

    localparam int LINE0  = 0;
    localparam int LINE1  = 1;
    localparam int STAT_W = 16;

endpackage

// File: rtl/fill_valve_arbiter_fill_timer.sv
// Shared cycle timer for the open (timeout) and settle phases.
// Clear has priority over enable; o_hit compares against the current terminal.
module fill_timer
    import fill_valve_arbiter_pkg::*;
#(
    parameter int TMR_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [TMR_W-1:0] i_term,
    output logic             o_hit
);

    logic [TMR_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_hit = (r_cnt == i_term);

endmodule

// File: rtl/fill_valve_arbiter.sv
// Round-robin arbiter sharing one filling valve between two bottling lines.
// Define FILL_STATS_EN to build the per-line completed-fill counters.
module fill_valve_arbiter
    import fill_valve_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1000,
    parameter int SETTLE_CYC  = 4,
    parameter int TMR_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req,
    input  logic [1:0]        level,
    input  logic              tank_ok,
    output logic [1:0]        grant,
    output logic              valve_open,
    output logic [1:0]        done,
    output logic [1:0]        fault,
    output logic              starved,
    output logic [STAT_W-1:0] fill_cnt0,
    output logic [STAT_W-1:0] fill_cnt1
);

    localparam logic [TMR_W-1:0] TO_TERM = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [TMR_W-1:0] ST_TERM = TMR_W'(SETTLE_CYC - 1);

    fv_state_t        r_state, w_state_nxt;
    logic [1:0]       r_grant, w_grant_nxt;
    logic [1:0]       r_done, w_done_nxt;
    logic [1:0]       r_fault, w_fault_nxt;
    logic             r_valve, w_valve_nxt;
    logic             r_starved, w_starved_nxt;
    logic             r_last, w_last_nxt;
    logic             w_own, w_win;
    logic             w_tmr_clr, w_tmr_en, w_tmr_hit;
    logic [TMR_W-1:0] w_term;

    // Owner index comes straight from the one-hot grant register
    assign w_own  = r_grant[LINE1];
    assign w_win  = (req == 2'b11) ? ~r_last : req[LINE1];
    assign w_term = (r_state == SETTLE) ? ST_TERM : TO_TERM;

    fill_timer #(
        .TMR_W (TMR_W)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .i_clr  (w_tmr_clr),
        .i_en   (w_tmr_en),
        .i_term (w_term),
        .o_hit  (w_tmr_hit)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_last_nxt    = r_last;
        w_done_nxt    = 2'b00;
        w_fault_nxt   = 2'b00;
        w_valve_nxt   = 1'b0;
        w_starved_nxt = 1'b0;
        w_tmr_clr     = 1'b0;
        w_tmr_en      = 1'b0;
        case (r_state)
            IDLE: begin
                w_grant_nxt = 2'b00;
                if (req != 2'b00) begin
                    w_state_nxt   = OPEN;
                    w_grant_nxt   = w_win ? 2'b10 : 2'b01;
                    w_last_nxt    = w_win;
                    w_tmr_clr     = 1'b1;
                    w_valve_nxt   = tank_ok;
                    w_starved_nxt = ~tank_ok;
                end
            end
            OPEN: begin
                if (!req[w_own]) begin
                    w_state_nxt = SETTLE;
                    w_tmr_clr   = 1'b1;
                end else if (level[w_own]) begin
                    w_done_nxt[w_own] = 1'b1;
                    w_state_nxt       = SETTLE;
                    w_tmr_clr         = 1'b1;
                end else if (w_tmr_hit && tank_ok) begin
                    w_fault_nxt[w_own] = 1'b1;
                    w_state_nxt        = SETTLE;
                    w_tmr_clr          = 1'b1;
                end else if (!tank_ok) begin
                    w_starved_nxt = 1'b1;
                end else begin
                    w_valve_nxt = 1'b1;
                    w_tmr_en    = 1'b1;
                end
            end
            SETTLE: begin
                if (w_tmr_hit) begin
                    w_state_nxt = IDLE;
                    w_grant_nxt = 2'b00;
                end else begin
                    w_tmr_en = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_grant   <= 2'b00;
            r_last    <= 1'b1;
            r_done    <= 2'b00;
            r_fault   <= 2'b00;
            r_valve   <= 1'b0;
            r_starved <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_last    <= w_last_nxt;
            r_done    <= w_done_nxt;
            r_fault   <= w_fault_nxt;
            r_valve   <= w_valve_nxt;
            r_starved <= w_starved_nxt;
        end
    end

    assign grant      = r_grant;
    assign valve_open = r_valve;
    assign done       = r_done;
    assign fault      = r_fault;
    assign starved    = r_starved;

`ifdef FILL_STATS_EN
    logic [STAT_W-1:0] r_cnt0, r_cnt1;

    // Counters move on the same edge that launches the done pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (w_done_nxt[LINE0] && (r_cnt0 != '1))
                r_cnt0 <= r_cnt0 + 1'b1;
            if (w_done_nxt[LINE1] && (r_cnt1 != '1))
                r_cnt1 <= r_cnt1 + 1'b1;
        end
    end

    assign fill_cnt0 = r_cnt0;
    assign fill_cnt1 = r_cnt1;
`else
    assign fill_cnt0 = '0;
    assign fill_cnt1 = '0;
`endif

endmodule

// File: doc/fill_valve_arbiter.md
# fill_valve_arbiter

Shares the single filling valve and supply tank between two bottling-line sequencers. Each line raises a fill request while its bottle is in the filling position. The block grants the valve to one line at a time, round-robin. It drives the valve, ends the fill on that line's level sensor or on a timeout, and returns a one-cycle completion or fault pulse to the requesting line.

## Interface
Parameters:
- TIMEOUT_CYC, 1000: maximum valve-open cycles per fill before a fault; must be ≥2.
- SETTLE_CYC, 4: valve-closed drip/settle cycles after each fill, with grant still held; must be ≥1.
- TMR_W, 16: width of the shared cycle timer; must hold max(TIMEOUT_CYC, SETTLE_CYC).

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high.
- req  in  2  per-line fill request; level-held while the line is in its filling state.
- level  in  2  per-line fill-level sensor; 1 means the bottle is full.
- tank_ok  in  1  supply tank above its minimum level.
- grant  out  2  one-hot owner of the valve; 00 when free.
- valve_open  out  1  filling valve command.
- done  out  2  one-cycle pulse on a line when its fill completed normally.
- fault  out  2  one-cycle pulse on a line when its fill timed out.
- starved  out  1  high while a fill is paused by tank_ok=0.
- fill_cnt0, fill_cnt1  out  16 each  completed-fill counters (see Configuration).

## Operation
- States: IDLE, OPEN, SETTLE.
- IDLE:
  - If req is nonzero, select a winner.
  - When both lines request, the winner is the line not served last.
  - The last-served pointer resets to line 1, so line 0 wins the first contention.
  - Load grant, clear the timer, go to OPEN, and update the pointer to the winner.
- OPEN, checked in priority order:
  1. Owner's req=0 (line aborted): go to SETTLE with no done and no fault.
  2. Owner's level=1: pulse done[owner], go to SETTLE.
  3. Timer = TIMEOUT_CYC−1 with tank_ok=1: pulse fault[owner], go to SETTLE.
  4. tank_ok=0: valve_open=0, starved=1, timer frozen, remain in OPEN.
  5. Otherwise: valve_open=1, timer increments.
- SETTLE:
  - valve_open=0; grant is held.
  - The timer counts SETTLE_CYC cycles, then grant goes to 00 and the state returns to IDLE.
- Level sensor and timeout in the same cycle: level wins (done, not fault).
- The non-owner line's level and req are ignored until it is granted.
- done and fault are mutually exclusive and fire at most once per grant.
- Reset (asynchronous, at any point including mid-fill):
  - State goes to IDLE and the pointer to line 1.
  - grant, valve_open, done, fault, starved and the timer all go to 0.
  - Counters clear.

## Timing
- Request to grant and valve_open: 1 cycle. Request sampled in IDLE at cycle t, grant and valve_open high at t+1 (if tank_ok=1).
- level high sampled at cycle t in OPEN: valve_open low and done pulse at t+1.
- Timeout: with tank_ok held high, valve_open is high for exactly TIMEOUT_CYC cycles, and the fault pulse coincides with the first closed cycle.
- Grant release: grant stays high through SETTLE_CYC closed cycles, then is 00 for at least one IDLE cycle before the next grant.
- Minimum grant-to-grant spacing: fill length + SETTLE_CYC + 1 cycles.
- All outputs are registered. No combinational path from inputs to outputs.

## Configuration
- FILL_STATS_EN defined:
  - fill_cnt0 and fill_cnt1 increment on each done pulse of their line.
  - They saturate at 16'hFFFF and clear on reset.
- Undefined: the counters are not synthesized and both ports are tied to 0.
- Arbitration, timing and all other outputs are identical either way.

## Structure
- Shared package holds:
  - the state enumeration (IDLE=2'd0, OPEN=2'd1, SETTLE=2'd2);
  - the line-index constants LINE0 and LINE1;
  - the counter-width constant STAT_W=16.
- Sub-module fill_timer: a TMR_W-bit counter with clear, enable and a terminal-compare input, shared by the timeout and settle phases.
- Arbitration, pointer and output registers live in the top level.

## Test plan
- Single request: req=01, level[0] rises 20 cycles after grant → grant=01 one cycle after req, valve_open high 20 cycles, done=01 for 1 cycle, grant=00 after 4 settle cycles.
- Contention: req=11 from reset → line 0 served first, line 1 next. Line 1 then re-requests while line 0 requests → line 0 wins.
- Timeout: TIMEOUT_CYC=50, level stuck low → valve_open high exactly 50 cycles, fault=01 pulse, no done.
- Starvation: tank_ok low for 10 cycles mid-fill → valve_open low and starved high for those 10 cycles. The fault arrives 10 cycles later than without the pause.
- Abort and reset: owner drops req mid-fill → SETTLE with no pulses. Reset asserted mid-OPEN → all outputs 0 immediately, and the next contention goes to line 0.
- With FILL_STATS_EN: 3 good fills on line 1 → fill_cnt1=3, fill_cnt0=0. Without the macro, both read 0.
